// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, bubble encoding and front-end control actions for the IF/ID register.
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  typedef enum logic [1:0] {LOAD, HOLD, BUBBLE, CLEAR} pipe_ctrl_e;
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: width-parameterized register with load enable and synchronous clear to RST_VAL.
module pipe_reg #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d, q_q;
  always_comb q_d = clr ? RST_VAL : (en ? d : q_q);
  always_ff @(posedge clk) q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/if_id_pipe_reg.sv
// if_id_pipe_reg: IF/ID pipeline register with stall, flush and valid flag.
// Define IF_ID_PERF_CNT_EN to add stall/flush event counters.
module if_id_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] nextPcIN,
  input  logic [DATA_W-1:0] instruccionIN,
  output logic [DATA_W-1:0] nextPcOUT,
  output logic [DATA_W-1:0] instruccionOUT,
`ifdef IF_ID_PERF_CNT_EN
  output logic [31:0]       stallCntOUT,
  output logic [31:0]       flushCntOUT,
`endif
  output logic              validOUT
);
  pipe_ctrl_e ctrl;
  logic clr, en;
  // reset is decided first so X on stall/flush cannot reach the registers while it is high
  always_comb begin
    ctrl = reset ? CLEAR : flush ? BUBBLE : stall ? HOLD : LOAD;
    clr  = (ctrl == CLEAR) || (ctrl == BUBBLE);
    en   = (ctrl == LOAD);
  end

  pipe_reg #(.W(DATA_W), .RST_VAL('0)) u_pc (
    .clk(clk), .clr(clr), .en(en), .d(nextPcIN), .q(nextPcOUT)
  );
  pipe_reg #(.W(DATA_W), .RST_VAL(NOP_INSTR)) u_instr (
    .clk(clk), .clr(clr), .en(en), .d(instruccionIN), .q(instruccionOUT)
  );
  pipe_reg #(.W(1), .RST_VAL(1'b0)) u_valid (
    .clk(clk), .clr(clr), .en(en), .d(1'b1), .q(validOUT)
  );

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
  always_comb begin
    stall_cnt_d = (ctrl == CLEAR) ? '0 : stall_cnt_q + 32'(ctrl == HOLD);
    flush_cnt_d = (ctrl == CLEAR) ? '0 : flush_cnt_q + 32'(ctrl == BUBBLE);
  end
  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end
  assign stallCntOUT = stall_cnt_q;
  assign flushCntOUT = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb_if_id_pipe_reg: directed scoreboard bench for if_id_pipe_reg (honours IF_ID_PERF_CNT_EN).
module tb_if_id_pipe_reg;
  logic clk = 1'b0, reset, stall, flush, valid_o;
  logic [31:0] pc_i, ins_i, pc_o, ins_o, sc_o, fc_o;
  int n_cmp = 0, n_bad = 0;

  typedef struct {logic [31:0] pc, ins, sc, fc; logic v;} exp_t;
  exp_t sb[$];
  exp_t m = '{pc: 32'h0, ins: 32'h0, sc: 32'h0, fc: 32'h0, v: 1'b0};

  always #50 clk = ~clk;

  if_id_pipe_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .nextPcIN(pc_i), .instruccionIN(ins_i),
    .nextPcOUT(pc_o), .instruccionOUT(ins_o),
`ifdef IF_ID_PERF_CNT_EN
    .stallCntOUT(sc_o), .flushCntOUT(fc_o),
`endif
    .validOUT(valid_o)
  );
`ifndef IF_ID_PERF_CNT_EN
  assign sc_o = '0;
  assign fc_o = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".pc"}, pc_o, e.pc);
    chk({tag, ".ins"}, ins_o, e.ins);
    chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, e.v});
`ifdef IF_ID_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, sc_o, e.sc);
    chk({tag, ".flush_cnt"}, fc_o, e.fc);
`endif
  endtask

  task automatic step(input string tag, input logic r, input logic s, input logic f,
                      input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    @(negedge clk);
    reset = r; stall = s; flush = f; pc_i = pc; ins_i = ins;
    #1 chk({tag, ".noflowthru"}, pc_o, m.pc);
    if (r === 1'b1) begin
      m = '{pc: 32'h0, ins: 32'h0, sc: 32'h0, fc: 32'h0, v: 1'b0};
    end else if (f) begin
      m.pc = 32'h0; m.ins = 32'h0; m.v = 1'b0; m.fc = m.fc + 1;
    end else if (s) begin
      m.sc = m.sc + 1;
    end else begin
      m.pc = pc; m.ins = ins; m.v = 1'b1;
    end
    sb.push_back(m);
    @(posedge clk);
    #1 e = sb.pop_front();
    check_all(tag, e);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; pc_i = '0; ins_i = '0;
    step("rst0", 1, 0, 0, 32'h1, 32'h1);
    step("rst1", 1, 0, 0, 32'h1, 32'h1);
    step("rstx", 1, 1'bx, 1'bx, 32'h1, 32'h1);
    for (int k = 0; k < 3; k++) begin
      step("ld1", 0, 0, 0, 32'h1, 32'h1);
      step("ld0", 0, 0, 0, 32'h0, 32'h0);
      step("ldlo", 0, 0, 0, 32'h0000FFFF, 32'h11110000);
      step("ldhi", 0, 0, 0, 32'hFFFF0000, 32'hFFFF0000);
    end
    step("preld", 0, 0, 0, 32'h0000FFFF, 32'h11110000);
    for (int k = 0; k < 3; k++) step("stall", 0, 1, 0, 32'hFFFF0000, 32'hFFFF0000);
    step("release", 0, 0, 0, 32'hFFFF0000, 32'hFFFF0000);
    step("flushstall", 0, 1, 1, 32'h12345678, 32'h9ABCDEF0);
    step("reload", 0, 0, 0, 32'hCAFE0004, 32'h8C220000);
    step("flush2", 0, 0, 1, 32'h5, 32'h5);
`ifdef IF_ID_PERF_CNT_EN
    chk("cnt.stall3", sc_o, 32'd3);
    chk("cnt.flush2", fc_o, 32'd2);
`endif
    step("reload2", 0, 0, 0, 32'hA5A5A5A5, 32'h5A5A5A5A);
    step("rstload", 1, 0, 0, 32'hFFFF0000, 32'hFFFF0000);
`ifdef IF_ID_PERF_CNT_EN
    chk("cnt.stall0", sc_o, 32'd0);
    chk("cnt.flush0", fc_o, 32'd0);
`endif
    step("postrst", 0, 0, 0, 32'h00000040, 32'h20080001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
